ascii_text_renderer: RTL and testbench

ASCII_TEXT_RENDERER -- requirements
Module: ascii_text_renderer

---
 rtl/ascii_text_renderer_pkg.sv | 37 +++
 rtl/ascii_text_renderer_text_buffer_ram.sv | 36 +++
 rtl/ascii_text_renderer.sv | 139 +++++++++++++
 tb/tb_ascii_text_renderer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_text_renderer_pkg.sv
// ascii_text_renderer_pkg
// Shared display constants and address-packing helpers for the text renderer.
// Holds the colour width, the character cell geometry, the pixel pipeline
// latency and the text-buffer / font-ROM address formats.
package ascii_text_renderer_pkg;

    localparam int RGB_W    = 12;               // RGB444 colour width
    localparam int CELL_W   = 8;                // pixels per character cell
    localparam int CELL_H   = 16;               // lines per character cell
    localparam int XW       = $clog2(CELL_W);   // pixel-in-cell index width
    localparam int YW       = $clog2(CELL_H);   // line-in-cell index width
    localparam int PIPE_LAT = 3;                // pixel in -> rgb out, clocks
    localparam int TBUF_AW  = 12;               // text buffer address width
    localparam int TBUF_DW  = 8;                // {inverse, ascii[6:0]}
    localparam int FONT_AW  = 11;               // {code[6:0], line[3:0]}

    // Text buffer address: {row[4:0], col[6:0]}.
    function automatic logic [TBUF_AW-1:0] tbuf_addr(input logic [4:0] row,
                                                     input logic [6:0] col);
        return {row, col};
    endfunction

    // Font ROM address: {code[6:0], line[3:0]}.
    function automatic logic [FONT_AW-1:0] font_addr(input logic [6:0] code,
                                                     input logic [YW-1:0] line);
        return {code, line};
    endfunction

    // True when a character cell lies inside the visible text grid.
    function automatic logic cell_in_range(input logic [6:0] col,
                                           input logic [5:0] row,
                                           input int cols,
                                           input int rows);
        return (int'(col) < cols) && (int'(row) < rows);
    endfunction

endpackage

// File: rtl/ascii_text_renderer_text_buffer_ram.sv
// text_buffer_ram
// Single-write, single-read RAM with a registered read port. A write and a
// read of the same address on the same edge return the previous contents
// (read-first). No reset: contents survive the renderer's reset.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address, sampled every clock
//   rdata_o  - registered read data, valid one clock after raddr_i
module text_buffer_ram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ascii_text_renderer.sv
// ascii_text_renderer
// Character-cell text overlay: looks up the character under the current
// pixel, fetches its glyph line from an external font ROM and emits the
// pixel colour three clocks later, with the sync/active flags delayed to match.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   pixel_x, pixel_y, video_on    - pixel position and active flag (cycle T)
//   hsync_in, vsync_in            - raw syncs
//   wr_en, wr_addr, wr_char       - host write: {row,col}, {inverse, ascii}
//   font_bitmap_addr              - font ROM address {code, line} (cycle T+1)
//   font_bitmap_byte              - font ROM data (cycle T+2), MSB = leftmost
//   rgb                           - pixel colour (after edge T+3)
//   hsync_out, vsync_out, video_on_out - syncs/active flag aligned with rgb
module ascii_text_renderer
    import ascii_text_renderer_pkg::*;
#(
    parameter int                TEXT_COLS = 80,
    parameter int                TEXT_ROWS = 30,
    parameter logic [RGB_W-1:0]  FG_COLOR  = 12'hFFF,
    parameter logic [RGB_W-1:0]  BG_COLOR  = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          pixel_x,
    input  logic [9:0]          pixel_y,
    input  logic                video_on,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                wr_en,
    input  logic [TBUF_AW-1:0]  wr_addr,
    input  logic [TBUF_DW-1:0]  wr_char,
    output logic [FONT_AW-1:0]  font_bitmap_addr,
    input  logic [7:0]          font_bitmap_byte,
    output logic [RGB_W-1:0]    rgb,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                video_on_out
);

    logic [TBUF_AW-1:0] rd_addr;
    logic               wr_ok;
    logic [TBUF_DW-1:0] rd_char;

    assign rd_addr = tbuf_addr(pixel_y[8:4], pixel_x[9:3]);
    assign wr_ok   = wr_en && cell_in_range(wr_addr[6:0], {1'b0, wr_addr[11:7]},
                                            TEXT_COLS, TEXT_ROWS);

    text_buffer_ram #(.AW(TBUF_AW), .DW(TBUF_DW)) u_text_buffer_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_addr),
        .wdata_i (wr_char),
        .raddr_i (rd_addr),
        .rdata_o (rd_char)
    );

    // Stage 1 (aligned with rd_char) and stage 2 (aligned with font byte).
    logic [XW-1:0]      x1_q, x2_q;
    logic [YW-1:0]      y1_q;
    logic [TBUF_AW-1:0] key1_q;
    logic               vis1_q, vis2_q;
    logic               live1_q;
    logic               inv2_q;

    // Character held for the remainder of the current cell so that a host
    // write landing mid-cell cannot split one cell between two glyphs.
    logic [TBUF_DW-1:0] held_char_q;
    logic [TBUF_AW-1:0] held_key_q;
    logic               held_vld_q;
    logic               reload;
    logic [TBUF_DW-1:0] char_d;

    // {video_on, vsync, hsync} delay line, one entry per pipeline stage.
    logic [2:0]         ctl_q [PIPE_LAT];

    logic               pix_bit;
    logic [RGB_W-1:0]   rgb_d, rgb_q;

    // A fresh fetch is taken on the first pixel of a cell, on any change of
    // cell (non-sequential scans) and on the first pixel after reset.
    always_comb begin
        reload = !held_vld_q || (x1_q == '0) || (key1_q != held_key_q);
        char_d = reload ? rd_char : held_char_q;
    end

    assign font_bitmap_addr = live1_q ? font_addr(char_d[6:0], y1_q) : '0;

    always_comb begin
        pix_bit = font_bitmap_byte[XW'(CELL_W - 1) - x2_q] ^ inv2_q;
        rgb_d   = '0;
        if (vis2_q) begin
            rgb_d = pix_bit ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q        <= '0;
            y1_q        <= '0;
            key1_q      <= '0;
            vis1_q      <= 1'b0;
            live1_q     <= 1'b0;
            held_char_q <= '0;
            held_key_q  <= '0;
            held_vld_q  <= 1'b0;
            x2_q        <= '0;
            inv2_q      <= 1'b0;
            vis2_q      <= 1'b0;
            rgb_q       <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                ctl_q[i] <= '0;
            end
        end else begin
            x1_q        <= pixel_x[XW-1:0];
            y1_q        <= pixel_y[YW-1:0];
            key1_q      <= rd_addr;
            vis1_q      <= video_on && cell_in_range(pixel_x[9:3], pixel_y[9:4],
                                                     TEXT_COLS, TEXT_ROWS);
            live1_q     <= 1'b1;
            held_char_q <= char_d;
            held_key_q  <= key1_q;
            held_vld_q  <= live1_q;
            x2_q        <= x1_q;
            inv2_q      <= char_d[7];
            vis2_q      <= vis1_q;
            rgb_q       <= rgb_d;
            ctl_q[0]    <= {video_on, vsync_in, hsync_in};
            for (int i = 1; i < PIPE_LAT; i++) begin
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

    assign rgb          = rgb_q;
    assign video_on_out = ctl_q[PIPE_LAT-1][2];
    assign vsync_out    = ctl_q[PIPE_LAT-1][1];
    assign hsync_out    = ctl_q[PIPE_LAT-1][0];

endmodule

// File: tb/tb_ascii_text_renderer.sv
// tb_ascii_text_renderer
// Bench for ascii_text_renderer: a registered font ROM model, a cell-level
// reference model of the text display with an expected-output queue, glyph
// tables for the 'A' cell and directed sequences for blanking, sync delay,
// same-cycle write, ignored writes and mid-line reset, then random scans.
module tb_ascii_text_renderer;

    localparam logic [11:0] FG   = 12'hEDB;
    localparam logic [11:0] BG   = 12'h135;
    localparam int          COLS = 80;
    localparam int          ROWS = 30;

    localparam logic [9:0] BLK_X [5] = '{10'd0, 10'd640, 10'd700, 10'd8, 10'd1016};
    localparam logic [9:0] BLK_Y [5] = '{10'd2, 10'd0, 10'd100, 10'd480, 10'd0};
    localparam logic       BLK_V [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_char = '0;
    logic [10:0] font_bitmap_addr;
    logic [7:0]  font_bitmap_byte = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, video_on_out;

    always #5 clk = ~clk;

    ascii_text_renderer #(
        .TEXT_COLS(COLS), .TEXT_ROWS(ROWS), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .font_bitmap_addr(font_bitmap_addr), .font_bitmap_byte(font_bitmap_byte),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .video_on_out(video_on_out)
    );

    function automatic logic [7:0] glyph_a(input logic [3:0] line);
        case (line)
            4'd2:  return 8'h10;
            4'd3:  return 8'h38;
            4'd4:  return 8'h6C;
            4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: return 8'hC6;
            4'd7:  return 8'hFE;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        if (a[10:4] == 7'h41) return glyph_a(a[3:0]);
        if (a[10:4] == 7'h00) return 8'h00;
        return 8'(a[7:0] * 8'd37) ^ {1'b0, a[10:4]};
    endfunction

    // Font ROM: data valid one clock after the address.
    always @(posedge clk) font_bitmap_byte <= font_fn(font_bitmap_addr);

    // ---------------- scoreboard / reference model ----------------
    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vid;
    } exp_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [10:0] fa;
        logic [11:0] rgb;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vec[128];
    logic [7:0]  m_buf [4096];
    logic [7:0]  m_char;
    logic [11:0] m_key;
    logic        m_vld;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        z = '0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        m_vld = 1'b0;
    endtask

    // One pixel clock: drive inputs, predict, clock, then compare.
    task automatic step(input logic [9:0] px, input logic [9:0] py, input logic von,
                        input logic hs, input logic vs, input logic we,
                        input logic [11:0] wa, input logic [7:0] wc);
        logic [11:0] ra;
        logic [7:0]  snap, g;
        logic [10:0] fa;
        logic        in_rng, b;
        exp_t        e, ex;
        pixel_x = px; pixel_y = py; video_on = von; hsync_in = hs; vsync_in = vs;
        wr_en = we; wr_addr = wa; wr_char = wc;
        ra   = {py[8:4], px[9:3]};
        snap = m_buf[ra];
        if (we && int'(wa[6:0]) < COLS && int'(wa[11:7]) < ROWS) m_buf[wa] = wc;
        // One character per cell visit: fetched on entry to the cell.
        if (!m_vld || px[2:0] == 3'd0 || ra != m_key) m_char = snap;
        m_key  = ra;
        m_vld  = 1'b1;
        in_rng = (int'(px[9:3]) < COLS) && (int'(py[9:4]) < ROWS);
        fa     = {m_char[6:0], py[3:0]};
        g      = font_fn(fa);
        b      = g[3'd7 - px[2:0]] ^ m_char[7];
        e      = '0;
        e.rgb  = (von && in_rng) ? (b ? FG : BG) : 12'h000;
        e.hs   = hs;
        e.vs   = vs;
        e.vid  = von;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (in_rng) chk("font_addr", 32'(font_bitmap_addr), 32'(fa));
        if (exp_q.size() > 2) begin
            ex = exp_q.pop_front();
            chk("rgb", 32'(rgb), 32'(ex.rgb));
            chk("hsync_out", 32'(hsync_out), 32'(ex.hs));
            chk("vsync_out", 32'(vsync_out), 32'(ex.vs));
            chk("video_on_out", 32'(video_on_out), 32'(ex.vid));
        end
    endtask

    task automatic idle();
        step(10'd1000, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
    endtask

    task automatic host_wr(input logic [11:0] wa, input logic [7:0] wc);
        step(10'd1000, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, wa, wc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb"}, 32'(rgb), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync_out), 32'd0);
        chk({tag, "_vsync"}, 32'(vsync_out), 32'd0);
        chk({tag, "_video_on"}, 32'(video_on_out), 32'd0);
        chk({tag, "_font_addr"}, 32'(font_bitmap_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_zero("rst_now");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_table(input logic inv);
        logic [11:0] er;
        for (int i = 0; i < 130; i++) begin
            if (i < 128) step(vec[i].x, vec[i].y, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
            else idle();
            if (i < 128) chk("tbl_font_addr", 32'(font_bitmap_addr), 32'(vec[i].fa));
            if (i >= 2) begin
                er = vec[i-2].rgb;
                if (inv) er = (er == FG) ? BG : FG;
                chk("tbl_rgb", 32'(rgb), 32'(er));
            end
        end
    endtask

    initial begin
        logic [7:0]  old_c, new_c, g;
        logic [7:0]  orig [4];
        logic [6:0]  col;
        logic [4:0]  row;
        logic [3:0]  line;
        logic        von;
        logic [11:0] wa;

        for (int y = 0; y < 16; y++) begin
            g = glyph_a(4'(y));
            for (int x = 0; x < 8; x++) begin
                vec[y*8+x].x   = 10'(x);
                vec[y*8+x].y   = 10'(y);
                vec[y*8+x].fa  = 11'h410 + 11'(y);
                vec[y*8+x].rgb = g[7-x] ? FG : BG;
            end
        end
        for (int i = 0; i < 4096; i++) m_buf[i] = 8'h00;

        // Reset state.
        @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        model_reset();

        // Fill the visible grid.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                host_wr({5'(r), 7'(c)}, 8'($urandom));

        // 'A' cell, normal then inverse.
        host_wr(12'h000, 8'h41);
        run_table(1'b0);
        host_wr(12'h000, 8'hC1);
        run_table(1'b1);

        // Blanking and sync alignment.
        for (int j = 0; j < 7; j++) begin
            if (j < 5) step(BLK_X[j], BLK_Y[j], BLK_V[j], 1'(j == 0), 1'(j == 1),
                            1'b0, 12'd0, 8'd0);
            else idle();
            if (j >= 2) chk("blank_rgb", 32'(rgb), 32'd0);
            chk("hsync_delay", 32'(hsync_out), 32'(j == 2));
            chk("vsync_delay", 32'(vsync_out), 32'(j == 3));
        end

        // Write to the cell being read: old glyph for this visit, new on the next.
        old_c = m_buf[259];
        new_c = old_c ^ 8'h5A;
        for (int x = 0; x < 8; x++) begin
            step(10'(24 + x), 10'd32, 1'b1, 1'b0, 1'b0, 1'(x == 0), 12'd259, new_c);
            if (x == 0) chk("rw_old_char", 32'(font_bitmap_addr), 32'({old_c[6:0], 4'd0}));
        end
        for (int x = 0; x < 8; x++) begin
            step(10'(24 + x), 10'd33, 1'b1, 1'b0, 1'b0, 1'(x == 4), 12'd259, 8'h33);
            if (x == 0) chk("rw_new_char", 32'(font_bitmap_addr), 32'({new_c[6:0], 4'd1}));
        end
        for (int x = 0; x < 8; x++) step(10'(24 + x), 10'd34, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);

        // Out-of-grid writes are dropped; the last visible cell is writable.
        for (int c = 0; c < 4; c++) orig[c] = m_buf[c];
        host_wr({5'd0, 7'd80}, 8'hFF);
        host_wr({5'd0, 7'd127}, 8'hFF);
        host_wr({5'd30, 7'd0}, 8'hFF);
        host_wr({5'd31, 7'd5}, 8'hFF);
        host_wr({5'd29, 7'd79}, 8'h2B);
        for (int c = 0; c < 4; c++)
            for (int x = 0; x < 8; x++) begin
                step(10'(c*8 + x), 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
                if (x == 0) chk("ignored_wr", 32'(font_bitmap_addr), 32'({orig[c][6:0], 4'd5}));
            end
        for (int x = 0; x < 8; x++) begin
            step(10'(632 + x), 10'd470, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
            if (x == 0) chk("last_cell_wr", 32'(font_bitmap_addr), 32'({7'h2B, 4'd6}));
        end

        // Reset in the middle of a line.
        for (int x = 0; x < 4; x++) step(10'(x), 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 8'd0);
        do_reset();
        for (int x = 4; x < 8; x++) begin
            step(10'(x), 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 8'd0);
            if (x == 4) chk("post_rst_char", 32'(font_bitmap_addr), 32'({7'h41, 4'd4}));
            if (x < 6) chk("post_rst_black", 32'(rgb), 32'd0);
        end
        for (int x = 0; x < 8; x++) step(10'(x), 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);

        // Random scans with random host writes.
        for (int n = 0; n < 150; n++) begin
            col  = 7'($urandom_range(0, 90));
            row  = 5'($urandom_range(0, 31));
            line = 4'($urandom_range(0, 15));
            von  = ($urandom_range(0, 7) != 0);
            for (int x = 0; x < 8; x++) begin
                if ($urandom_range(0, 1) == 1) wa = {row, col};
                else wa = {5'($urandom_range(0, 31)), 7'($urandom_range(0, 90))};
                step({col, 3'(x)}, {1'b0, row, line}, von,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), wa, 8'($urandom));
            end
        end
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
